hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_pkg.sv | 23 ++
 rtl/hilo_ctrl_lat_counter.sv | 28 ++
 rtl/hilo_ctrl.sv | 115 +++++++++++
 tb/tb_hilo_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result controller.
package hilo_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned DEF_MULT_LAT = 2;
  localparam int unsigned DEF_DIV_LAT  = 33;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/hilo_ctrl_lat_counter.sv
// Loadable 6-bit latency down-counter with a zero flag.
module lat_counter
  import hilo_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: waits out multiplier/divider latency, then captures the result.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_sel,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic [DATA_W-1:0] div_rem,
  input  logic [DATA_W-1:0] div_quo,
  input  logic              div_zero,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              dz_err
);

  state_t           state, state_nxt;
  logic             op_q;
  logic             cnt_zero_c, cnt_load_c, cnt_dec_c;
  logic [CNT_W-1:0] lat_val_c;
  hilo_t            hilo_q, hilo_nxt;
  logic             busy_nxt, done_nxt, dz_nxt;

  lat_counter u_lat_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load_c),
    .load_val (lat_val_c),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_start)   state_nxt = WAIT;
      WAIT:    if (cnt_zero_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath decode; moves only land in IDLE when no op is starting
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    lat_val_c  = op_sel ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
    hilo_nxt   = hilo_q;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    dz_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cnt_load_c = op_start;
        busy_nxt   = op_start;
        if (!op_start) begin
          if (mthi) hilo_nxt.hi = wdata;
          if (mtlo) hilo_nxt.lo = wdata;
        end
      end
      WAIT: begin
        cnt_dec_c = !cnt_zero_c;
        busy_nxt  = !cnt_zero_c;
        if (cnt_zero_c) begin
          done_nxt = 1'b1;
          if (op_q == OP_DIV) begin
            dz_nxt = div_zero;
            if (!div_zero) hilo_nxt = '{hi: div_rem, lo: div_quo};
          end else begin
            hilo_nxt = '{hi: mult_hi, lo: mult_lo};
          end
        end
      end
      default: ;
    endcase
  end

  // Result registers and registered status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hilo_q <= '0;
      op_q   <= OP_MULT;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz_err <= 1'b0;
    end else begin
      hilo_q <= hilo_nxt;
      if (cnt_load_c) op_q <= op_sel;
      busy   <= busy_nxt;
      done   <= done_nxt;
      dz_err <= dz_nxt;
    end
  end

  assign hi = hilo_q.hi;
  assign lo = hilo_q.lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed scoreboard bench for hilo_ctrl.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int unsigned MLAT = 2;
  localparam int unsigned DLAT = 33;

  logic        clock = 1'b0;
  logic        reset_n, op_start, op_sel, div_zero, mthi, mtlo;
  logic [31:0] mult_hi, mult_lo, div_rem, div_quo, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, dz_err;

  always #5 clock = ~clock;

  hilo_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clock(clock), .reset_n(reset_n), .op_start(op_start), .op_sel(op_sel),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_rem(div_rem), .div_quo(div_quo),
    .div_zero(div_zero), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz_err(dz_err)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Drive a one-cycle op_start and queue the expected outcome.
  task automatic start_op(input logic sel, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.start = cyc;
    e.lat = int'(sel ? DLAT : MLAT);
    sb.push_back(e);
    op_sel = sel; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait (bounded) for done, compare against the scoreboard head, then poke op_start in DONE.
  task automatic wait_done(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < e.lat + 10 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - e.start), 32'(e.lat + 1));
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
      check({tag, "_dz_err"}, 32'(dz_err), 32'(e.dz));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      op_sel = 1'b0; op_start = 1'b1;
      tick();
      op_start = 1'b0;
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic count_done(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; op_start = 1'b0; op_sel = 1'b0; div_zero = 1'b0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    mult_hi = '0; mult_lo = '0; div_rem = '0; div_quo = '0;
    tick(); tick();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz_err", 32'(dz_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // 3 x -2
    mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFFA;
    start_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    wait_done("mult");

    // 7 / 2
    div_rem = 32'd1; div_quo = 32'd3;
    start_op(OP_DIV, 32'd1, 32'd3, 1'b0);
    wait_done("div");

    // Preload then divide by zero: HI/LO must hold
    wdata = 32'hAAAA_0000; mthi = 1'b1; tick(); mthi = 1'b0;
    wdata = 32'h0000_BBBB; mtlo = 1'b1; tick(); mtlo = 1'b0;
    check("mthi_only", hi, 32'hAAAA_0000);
    check("mtlo_only", lo, 32'h0000_BBBB);
    div_rem = 32'h9999_9999; div_quo = 32'h8888_8888; div_zero = 1'b1;
    start_op(OP_DIV, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    wait_done("divzero");
    div_zero = 1'b0;

    // Re-pulsed start and mthi while busy are both dropped
    mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
    start_op(OP_MULT, 32'h1111_1111, 32'h2222_2222, 1'b0);
    op_start = 1'b1; op_sel = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    op_start = 1'b0; mthi = 1'b0;
    wait_done("restart");
    count_done("restart_no_second_done", 40);

    // Dual move in IDLE, then dual move dropped when op_start coincides
    wdata = 32'h1234_5678; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("move_both_hi", hi, 32'h1234_5678);
    check("move_both_lo", lo, 32'h1234_5678);
    mult_hi = 32'h0BAD_F00D; mult_lo = 32'h0000_CAFE;
    wdata = 32'h5555_5555; mthi = 1'b1; mtlo = 1'b1;
    start_op(OP_MULT, 32'h0BAD_F00D, 32'h0000_CAFE, 1'b0);
    mthi = 1'b0; mtlo = 1'b0;
    check("move_dropped_hi", hi, 32'h1234_5678);
    check("move_dropped_lo", lo, 32'h1234_5678);
    wait_done("mult_vs_move");

    // Reset during WAIT aborts the divide
    div_rem = 32'h7777_7777; div_quo = 32'h6666_6666;
    op_sel = OP_DIV; op_start = 1'b1;
    tick();
    op_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    count_done("abort_no_done", 50);
    check("abort_hi_held", hi, 32'h0);

    // Controller still works after the abort: 3 x 2
    mult_hi = 32'h0; mult_lo = 32'h6;
    start_op(OP_MULT, 32'h0, 32'h6, 1'b0);
    wait_done("mult_after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
